// File: rtl/alu16_seq_ctrl.sv
// alu16_seq_ctrl: sequencer that runs ADD, SUB and unsigned 16x16 MUL
// commands through one external alu16bit instance. Multiplication is
// shift-and-add over 16 ALU passes, with the ALU doing every addition.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The controller never withdraws rsp_valid, and never changes
// the rsp_* fields, until that transfer has happened. req_ready is high only
// in IDLE.
//
// State encoding on dbg_state: 0 IDLE, 1 EXEC, 2 MUL, 3 DONE.
module alu16_seq_ctrl #(
  parameter logic [2:0] OP_ADD = 3'b010,
  parameter logic [2:0] OP_AND = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  // command side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_cmd,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_hi,
  output logic [15:0] rsp_lo,
  output logic        rsp_cout,
  output logic        rsp_err,
  // external ALU drive
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic        alu_ainvert,
  output logic        alu_binvert,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_cout,
  // debug
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] CMD_ADD = 2'b00;
  localparam logic [1:0] CMD_SUB = 2'b01;
  localparam logic [1:0] CMD_MUL = 2'b10;

  state_e      state_q;

  // multiplier working registers: {hi_q, lo_q} is the running partial product,
  // lo_q initially holds the multiplier B and is shifted out LSB first
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic [4:0]  cnt_q;

  logic        rsp_valid_q;
  logic [15:0] rsp_hi_q;
  logic [15:0] rsp_lo_q;
  logic        rsp_cout_q;
  logic        rsp_err_q;

  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic        alu_cin_q;
  logic        alu_ainvert_q;
  logic        alu_binvert_q;
  logic [2:0]  alu_op_q;

  logic [15:0] mul_hi_d;
  logic [15:0] mul_lo_d;

  // One shift-and-add step. The ALU is currently computing hi + A; when the
  // multiplier bit is set that 17-bit sum is kept, otherwise hi is kept.
  // Either way the 33-bit value is shifted right by one into {hi, lo}.
  always_comb begin
    mul_hi_d = {1'b0, hi_q[15:1]};
    mul_lo_d = {hi_q[0], lo_q[15:1]};
    if (lo_q[0]) begin
      mul_hi_d = {alu_cout, alu_result[15:1]};
      mul_lo_d = {alu_result[0], lo_q[15:1]};
    end
  end

  // Controller FSM with registered response and ALU-drive outputs.
  // The ALU drive vector for a state is loaded on the edge that enters it,
  // so the ALU result is ready to be captured on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hi_q          <= 16'h0000;
      lo_q          <= 16'h0000;
      cnt_q         <= 5'd0;
      rsp_valid_q   <= 1'b0;
      rsp_hi_q      <= 16'h0000;
      rsp_lo_q      <= 16'h0000;
      rsp_cout_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      alu_a_q       <= 16'h0000;
      alu_b_q       <= 16'h0000;
      alu_cin_q     <= 1'b0;
      alu_ainvert_q <= 1'b0;
      alu_binvert_q <= 1'b0;
      alu_op_q      <= OP_AND;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // fresh response fields for every accepted command
            rsp_hi_q   <= 16'h0000;
            rsp_lo_q   <= 16'h0000;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            case (req_cmd)
              CMD_ADD, CMD_SUB: begin
                // SUB is A + ~B + 1; carry-out 1 means no borrow
                alu_a_q       <= req_a;
                alu_b_q       <= req_b;
                alu_op_q      <= OP_ADD;
                alu_ainvert_q <= 1'b0;
                alu_binvert_q <= (req_cmd == CMD_SUB);
                alu_cin_q     <= (req_cmd == CMD_SUB);
                state_q       <= EXEC;
              end
              CMD_MUL: begin
                hi_q          <= 16'h0000;
                lo_q          <= req_b;
                cnt_q         <= 5'd0;
                alu_a_q       <= 16'h0000;
                alu_b_q       <= req_a;
                alu_op_q      <= OP_ADD;
                alu_ainvert_q <= 1'b0;
                alu_binvert_q <= 1'b0;
                alu_cin_q     <= 1'b0;
                state_q       <= MUL;
              end
              default: begin
                // illegal command: straight to DONE with only the error bit
                rsp_err_q   <= 1'b1;
                rsp_valid_q <= 1'b1;
                state_q     <= DONE;
              end
            endcase
          end
        end

        EXEC: begin
          rsp_lo_q      <= alu_result;
          rsp_cout_q    <= alu_cout;
          rsp_valid_q   <= 1'b1;
          alu_a_q       <= 16'h0000;
          alu_b_q       <= 16'h0000;
          alu_cin_q     <= 1'b0;
          alu_ainvert_q <= 1'b0;
          alu_binvert_q <= 1'b0;
          alu_op_q      <= OP_AND;
          state_q       <= DONE;
        end

        MUL: begin
          hi_q    <= mul_hi_d;
          lo_q    <= mul_lo_d;
          cnt_q   <= cnt_q + 5'd1;
          // next pass adds A to the new hi
          alu_a_q <= mul_hi_d;
          if (cnt_q == 5'd15) begin
            rsp_hi_q      <= mul_hi_d;
            rsp_lo_q      <= mul_lo_d;
            rsp_valid_q   <= 1'b1;
            alu_a_q       <= 16'h0000;
            alu_b_q       <= 16'h0000;
            alu_cin_q     <= 1'b0;
            alu_ainvert_q <= 1'b0;
            alu_binvert_q <= 1'b0;
            alu_op_q      <= OP_AND;
            state_q       <= DONE;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_lo      = rsp_lo_q;
  assign rsp_cout    = rsp_cout_q;
  assign rsp_err     = rsp_err_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign alu_ainvert = alu_ainvert_q;
  assign alu_binvert = alu_binvert_q;
  assign alu_op      = alu_op_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/alu16_seq_ctrl.md
ALU16_SEQ_CTRL -- requirements
Module: alu16_seq_ctrl

Interface
REQ-001 SHALL have parameter OP_ADD, default 3'b010, the alu16bit op code that selects the sum.
REQ-002 SHALL have parameter OP_AND, default 3'b000, the alu16bit op code that selects bitwise AND.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, which marks a command as present.
REQ-006 SHALL have port req_ready, output, 1, which means the controller accepts a command this cycle.
REQ-007 SHALL have port req_cmd, input, 2, encoded as: 00 ADD, 01 SUB, 10 MUL (unsigned), 11 illegal.
REQ-008 SHALL have ports req_a and req_b, input, 16 each, the operands.
REQ-009 SHALL have port rsp_valid, output, 1, which marks a result as present.
REQ-010 SHALL have port rsp_ready, input, 1, which means the consumer takes the result.
REQ-011 SHALL have port rsp_hi, output, 16, holding the upper product half; 0 for ADD/SUB.
REQ-012 SHALL have port rsp_lo, output, 16, holding the ADD/SUB result or the lower product half.
REQ-013 SHALL have port rsp_cout, output, 1, holding the ALU carry-out for ADD/SUB; 0 for MUL.
REQ-014 SHALL have port rsp_err, output, 1, set for an illegal command.
REQ-015 SHALL have ports alu_a and alu_b (output, 16), plus alu_cin, alu_ainvert and alu_binvert (output, 1 each) and alu_op (output, 3), which drive one external alu16bit instance.
REQ-016 SHALL have ports alu_result (input, 16) and alu_cout (input, 1), which return from that instance.

Function
REQ-017 SHALL implement the state machine IDLE, EXEC, MUL, DONE; it performs every addition or subtraction through the external ALU only.
REQ-018 SHALL assert req_ready only in IDLE; a command is accepted when req_valid and req_ready are both high in the same cycle (cycle T), and operands and cmd are registered at T.
REQ-019 SHALL transition IDLE->EXEC for cmd 00/01, IDLE->MUL for cmd 10, and IDLE->DONE for cmd 11 with rsp_err=1 and all result fields 0.
REQ-020 SHALL in EXEC drive alu_a=A, alu_b=B, alu_op=OP_ADD, alu_ainvert=0; ADD sets binvert=0 and cin=0; SUB sets binvert=1 and cin=1; rsp_lo<=alu_result and rsp_cout<=alu_cout; then EXEC->DONE.
REQ-021 SHALL give ADD/SUB rsp_valid at cycle T+2.
REQ-022 SHALL in MUL keep a 16-bit hi, a 16-bit lo (initialised hi=0, lo=B) and a 5-bit step counter starting at 0.
REQ-023 SHALL each MUL cycle drive alu_a=hi, alu_b=A, op=OP_ADD, cin=0, binvert=0; if lo[0]=1 then {hi,lo}<={alu_cout,alu_result,lo[15:1]}, else {hi,lo}<={1'b0,hi,lo[15:1]}.
REQ-024 SHALL leave MUL after exactly 16 iterations (counter 15 -> DONE), with {rsp_hi,rsp_lo}=A*B (32-bit, exact) and rsp_valid at cycle T+17.
REQ-025 SHALL in DONE hold rsp_valid=1 with all rsp_* stable until rsp_ready=1, then return to IDLE the next cycle; a rsp_ready seen in the same cycle as rsp_valid completes the transfer.
REQ-026 SHALL keep rsp_valid=0 outside DONE; no new command is accepted in DONE (no overlap; throughput is one command per 3 cycles minimum).
REQ-027 SHALL drive the ALU in IDLE and DONE with a quiescent vector: alu_a=alu_b=0, cin=ainvert=binvert=0, alu_op=OP_AND.
REQ-028 SHALL give all arithmetic modulo 2^16 per ALU pass; SUB borrow is reported as rsp_cout=0 (A<B unsigned), with no overflow flag.
REQ-029 SHALL ignore changes on req_* outside the accept cycle.

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE, clear rsp_valid, rsp_hi, rsp_lo, rsp_cout, rsp_err, hi, lo and the counter, and drive the quiescent ALU vector; req_ready=1 the cycle after reset is released.
REQ-031 SHALL when reset is asserted mid-EXEC, mid-MUL or in DONE abandon the operation with no response produced; rst has priority over every handshake.

Verification
REQ-032 SHALL cover ADD: A=0xFFFF, B=0x0001 -> rsp_lo=0x0000, rsp_cout=1, rsp_hi=0, rsp_valid at T+2.
REQ-033 SHALL cover SUB: A=0x0005, B=0x0007 -> rsp_lo=0xFFFE, rsp_cout=0; A=7, B=5 -> rsp_lo=0x0002, rsp_cout=1.
REQ-034 SHALL cover MUL: A=0xFFFF, B=0xFFFF -> rsp_hi=0xFFFE, rsp_lo=0x0001, rsp_valid at T+17; A=0x1234, B=0 -> 0x00000000.
REQ-035 SHALL cover backpressure: rsp_ready held 0 for 5 cycles after DONE -> outputs stable, req_ready=0 throughout, IDLE one cycle after rsp_ready=1.
REQ-036 SHALL cover an illegal cmd 11 -> rsp_valid at T+1, rsp_err=1, results 0; the next legal command gives rsp_err=0.
REQ-037 SHALL cover rst=1 at MUL step 8 -> rsp_valid never asserts, req_ready=1 after release, and a following ADD 3+4 -> rsp_lo=0x0007.
